// File: rtl/aes_dec_stream_ctrl.sv
// aes_dec_stream_ctrl: front-end sequencer for the pipelined AES_dec core.
// Handles key loading and expansion wait, streams ciphertext into the core,
// drains in-flight blocks before re-keying, and buffers plaintext in a FIFO
// whose depth also bounds the number of blocks that may be outstanding.
module aes_dec_stream_ctrl #(
  parameter int KEY_EXP_CYCLES = 12,
  parameter int OUT_DEPTH      = 16,
  localparam int CW            = $clog2(OUT_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [127:0]  key_in,
  output logic          key_busy,
  input  logic          ct_valid,
  output logic          ct_ready,
  input  logic [127:0]  ct_data,
  output logic          pt_valid,
  input  logic          pt_ready,
  output logic [127:0]  pt_data,
  output logic [127:0]  core_in,
  output logic [127:0]  core_key,
  output logic          core_enable,
  output logic          core_fsm_en,
  input  logic [127:0]  core_out,
  input  logic          core_valid_out,
  output logic [CW-1:0] inflight,
  output logic          err_spurious
);

  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int WCW = (KEY_EXP_CYCLES > 1) ? $clog2(KEY_EXP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_START = 3'd1,
    KEY_WAIT  = 3'd2,
    RUN       = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [127:0]    pending_key;
  logic [WCW-1:0]  wait_cnt;
  logic            wait_done;
  logic [127:0]    fifo_mem [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            accept;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(OUT_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign wait_done   = (wait_cnt == WCW'(KEY_EXP_CYCLES - 1));
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign ct_ready    = (state == RUN) && !key_load &&
                       (credit_used < (CW + 1)'(OUT_DEPTH));
  assign accept      = ct_valid && ct_ready;
  assign push        = core_valid_out && (inflight != '0);
  assign pt_valid    = (fifo_count != '0);
  assign pop         = pt_valid && pt_ready;
  assign pt_data     = pt_valid ? fifo_mem[rd_ptr] : '0;
  assign key_busy    = (state != RUN);
  assign core_fsm_en = (state == KEY_START);

  // State register for the key/stream sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a key request during key setup restarts the load.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (key_load) state_next = KEY_START;
      KEY_START: state_next = key_load ? KEY_START : KEY_WAIT;
      KEY_WAIT: begin
        if (key_load)       state_next = KEY_START;
        else if (wait_done) state_next = RUN;
      end
      RUN:       if (key_load) state_next = DRAIN;
      DRAIN:     if (inflight == '0) state_next = KEY_START;
      default:   state_next = IDLE;
    endcase
  end

  // Key registers: pending key follows the latest request, active key only moves in KEY_START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_key <= '0;
      core_key    <= '0;
    end else begin
      if (key_load)            pending_key <= key_in;
      if (state == KEY_START)  core_key    <= pending_key;
    end
  end

  // Key expansion wait counter, cleared while the load pulse is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wait_cnt <= '0;
    else if (state == KEY_START) wait_cnt <= '0;
    else if (state == KEY_WAIT)  wait_cnt <= wait_cnt + WCW'(1);
  end

  // Registered core input stage: data holds when nothing is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_in     <= '0;
      core_enable <= 1'b0;
    end else begin
      core_enable <= accept;
      if (accept) core_in <= ct_data;
    end
  end

  // In-flight counter spans the registered stage plus the core pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky flag for core results that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     err_spurious <= 1'b0;
    else if (core_valid_out && (inflight == '0))  err_spurious <= 1'b1;
  end

  // Output FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_out;
  end

  // Output FIFO pointers and occupancy; credit limit keeps pushes off a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// Testbench for aes_dec_stream_ctrl using a fixed-latency stub core whose
// output is the ciphertext XORed with the key present on core_key at output time.
module tb_aes_dec_stream_ctrl;

  localparam int KEY_EXP_CYCLES = 12;
  localparam int OUT_DEPTH      = 16;
  localparam int CW             = $clog2(OUT_DEPTH + 1);
  localparam int L              = 4;

  localparam logic [127:0] K1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] K3  = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;
  localparam logic [127:0] CT0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic          clk;
  logic          rst;
  logic          key_load;
  logic [127:0]  key_in;
  logic          key_busy;
  logic          ct_valid;
  logic          ct_ready;
  logic [127:0]  ct_data;
  logic          pt_valid;
  logic          pt_ready;
  logic [127:0]  pt_data;
  logic [127:0]  core_in;
  logic [127:0]  core_key;
  logic          core_enable;
  logic          core_fsm_en;
  logic [127:0]  core_out;
  logic          core_valid_out;
  logic [CW-1:0] inflight;
  logic          err_spurious;
  logic          inject;

  int chk;
  int errs;
  int acc_count;
  int pop_count;
  int fsm_en_count;
  int fsm_en_bad;
  logic [127:0] model_key;
  logic [127:0] sb_q[$];

  aes_dec_stream_ctrl #(
    .KEY_EXP_CYCLES(KEY_EXP_CYCLES),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .key_in(key_in), .key_busy(key_busy),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .core_in(core_in), .core_key(core_key), .core_enable(core_enable),
    .core_fsm_en(core_fsm_en), .core_out(core_out),
    .core_valid_out(core_valid_out), .inflight(inflight),
    .err_spurious(err_spurious)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub core: L-stage pipeline, key applied at the output.
  logic [L-1:0] pv;
  logic [127:0] pd [L];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < L; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[L-2:0], core_enable};
      pd[0] <= core_in;
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  end
  assign core_valid_out = pv[L-1] | inject;
  assign core_out       = inject ? 128'h0BAD : (pd[L-1] ^ core_key);

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push expected plaintext on accept, compare on each pop.
  always @(negedge clk) begin
    logic [127:0] exp;
    if (rst) begin
      if (ct_valid && ct_ready) begin
        sb_q.push_back(ct_data ^ model_key);
        acc_count++;
      end
      if (pt_valid && pt_ready) begin
        pop_count++;
        if (sb_q.size() == 0) begin
          chk++;
          errs++;
          $display("[TB] FAIL pt_unexpected: got %h with empty queue", pt_data);
        end else begin
          exp = sb_q.pop_front();
          check_output("pt_data", pt_data, exp);
        end
      end
      if (core_fsm_en) begin
        fsm_en_count++;
        if (inflight != '0) fsm_en_bad++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_key_ready(input int budget);
    int n = 0;
    @(negedge clk);
    while (key_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("key_ready_timeout", 128'(key_busy), 128'(0));
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || inflight != '0 || pt_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_timeout", 128'(sb_q.size()), 128'(0));
    tick();
  endtask

  task automatic apply_stimulus(input int n, input logic [127:0] base);
    for (int i = 0; i < n; i++) begin
      ct_valid = 1'b1;
      ct_data  = base + 128'(i);
      tick();
    end
    ct_valid = 1'b0;
  endtask

  typedef struct {
    logic fsm_en;
    logic busy;
    logic ready;
  } key_vec_t;

  key_vec_t kv[16];

  initial begin
    int a0;
    int p0;
    int f0;
    for (int i = 0; i < 16; i++) begin
      kv[i].fsm_en = (i == 1);
      kv[i].busy   = (i < 14);
      kv[i].ready  = (i >= 14);
    end
    chk = 0; errs = 0; acc_count = 0; pop_count = 0;
    fsm_en_count = 0; fsm_en_bad = 0;
    model_key = '0;
    rst = 1'b0; key_load = 1'b0; key_in = '0; ct_valid = 1'b0; ct_data = '0;
    pt_ready = 1'b0; inject = 1'b0;

    // Reset values
    #2;
    check_output("reset_busy", 128'(key_busy), 128'(1));
    check_output("reset_outs", {pt_valid, ct_ready, core_enable, core_fsm_en, err_spurious},
                 128'(0));
    check_output("reset_inflight", 128'(inflight), 128'(0));
    #10 rst = 1'b1;
    tick();

    // Test 1: key load timing table
    key_load = 1'b1; key_in = K1; model_key = K1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_output($sformatf("key_timing_%0d", i), {core_fsm_en, key_busy, ct_ready},
                   {kv[i].fsm_en, kv[i].busy, kv[i].ready});
      tick();
      key_load = 1'b0;
    end
    check_output("core_key_k1", core_key, K1);

    // Test 2: 11 back-to-back blocks
    pt_ready = 1'b1;
    a0 = acc_count; p0 = pop_count;
    for (int i = 0; i < 11; i++) begin
      ct_valid = 1'b1;
      ct_data  = CT0 + 128'(i * 7);
      @(negedge clk);
      check_output("ct_ready_stream", 128'(ct_ready), 128'(1));
      tick();
    end
    ct_valid = 1'b0;
    check_output("stream_accepts", 128'(acc_count - a0), 128'(11));
    wait_idle(60);
    check_output("stream_pops", 128'(pop_count - p0), 128'(11));

    // Test 3: consumer stall, credit limit
    pt_ready = 1'b0;
    a0 = acc_count; p0 = pop_count;
    for (int i = 0; i < 40; i++) begin
      ct_valid = 1'b1;
      ct_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    ct_valid = 1'b0;
    @(negedge clk);
    check_output("stall_accepts", 128'(acc_count - a0), 128'(OUT_DEPTH));
    check_output("stall_ready", 128'(ct_ready), 128'(0));
    check_output("stall_inflight", 128'(inflight), 128'(0));
    check_output("stall_err", 128'(err_spurious), 128'(0));
    tick();
    pt_ready = 1'b1;
    wait_idle(80);
    check_output("stall_pops", 128'(pop_count - p0), 128'(OUT_DEPTH));
    @(negedge clk);
    check_output("stall_resume", 128'(ct_ready), 128'(1));
    tick();

    // Test 4: re-key with 3 blocks in flight
    apply_stimulus(3, 128'h1111_0000);
    key_load = 1'b1; key_in = K2; ct_valid = 1'b1; ct_data = 128'hFFFF;
    @(negedge clk);
    check_output("rekey_ready_low", 128'(ct_ready), 128'(0));
    check_output("rekey_inflight", 128'(inflight), 128'(3));
    model_key = K2;
    f0 = fsm_en_count;
    tick();
    key_load = 1'b0; ct_valid = 1'b0;
    wait_key_ready(100);
    check_output("rekey_fsm_pulses", 128'(fsm_en_count - f0), 128'(1));
    check_output("core_key_k2", core_key, K2);
    apply_stimulus(1, 128'h2222_0000);
    wait_idle(40);

    // Test 5: asynchronous reset mid-stream
    pt_ready = 1'b0;
    apply_stimulus(7, 128'h3333_0000);
    check_output("pre_reset_inflight", 128'(inflight), 128'(5));
    check_output("pre_reset_pt_valid", 128'(pt_valid), 128'(1));
    #2 rst = 1'b0;
    #1;
    check_output("async_reset_outs",
                 {pt_valid, ct_ready, core_enable, core_fsm_en, err_spurious, ~key_busy},
                 128'(0));
    check_output("async_reset_data", pt_data | core_in | core_key, 128'(0));
    check_output("async_reset_inflight", 128'(inflight), 128'(0));
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ct_valid = 1'b1;
      @(negedge clk);
      check_output("post_reset_ready", 128'(ct_ready), 128'(0));
      tick();
    end
    ct_valid = 1'b0;
    key_load = 1'b1; key_in = K3; model_key = K3;
    tick();
    key_load = 1'b0;
    wait_key_ready(100);
    pt_ready = 1'b1;
    apply_stimulus(4, 128'h4444_0000);
    wait_idle(40);

    // Test 6: spurious core output
    pt_ready = 1'b0;
    p0 = pop_count;
    apply_stimulus(1, 128'h5555_0000);
    repeat (L + 3) tick();
    check_output("pre_spur_pt_valid", 128'(pt_valid), 128'(1));
    inject = 1'b1;
    tick();
    inject = 1'b0;
    @(negedge clk);
    check_output("spur_err", 128'(err_spurious), 128'(1));
    check_output("spur_inflight", 128'(inflight), 128'(0));
    repeat (5) tick();
    check_output("spur_sticky", 128'(err_spurious), 128'(1));
    pt_ready = 1'b1;
    wait_idle(20);
    check_output("spur_pops", 128'(pop_count - p0), 128'(1));

    check_output("fsm_en_with_inflight", 128'(fsm_en_bad), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
